relu_layer_seq: RTL and testbench

Sequencer for one 4-neuron dense layer of the Milestone 1 DNN. It clears the neuron accumulators, steps the shared input-feature/weight index through all layer inputs, and waits out the MAC pipeline. It then raises the ReLU `input_ready`, captures the four activated outputs into holding registers, and presents them to the next layer over a valid/ready handshake. It sits between the layer-input buffer/weight ROM, the four neuron MACs plus ReLU stage, and the next layer.

---
 rtl/relu_layer_seq_pkg.sv | 22 ++
 rtl/relu_layer_seq_if.sv | 42 ++++
 rtl/relu_layer_seq_down_counter.sv | 29 ++
 rtl/relu_layer_seq.sv | 143 ++++++++++++++
 tb/tb_relu_layer_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/relu_layer_seq_pkg.sv
// Shared types and defaults for the dense-layer ReLU sequencer.
package relu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      ACTIVATE,
      HOLD
   } seq_state_t;

   localparam int DEF_NUM_INPUTS = 8;
   localparam int DEF_DATA_W     = 12;
   localparam int DEF_MAC_LAT    = 2;

   // Index width for a count of n items; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/relu_layer_seq_if.sv
// Control/data bundle between the sequencer, neuron MACs, ReLU stage and next layer.
interface relu_layer_seq_if
   import relu_seq_pkg::*;
#(
   parameter int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int DATA_W     = DEF_DATA_W
);
   localparam int IW = idx_w(NUM_INPUTS);

   logic                     start;
   logic                     busy;
   logic [IW-1:0]            feat_idx;
   logic                     acc_clr;
   logic                     mac_en;
   logic                     relu_in_ready;
   logic                     relu_out_ready;
   logic signed [DATA_W-1:0] relu_out0;
   logic signed [DATA_W-1:0] relu_out1;
   logic signed [DATA_W-1:0] relu_out2;
   logic signed [DATA_W-1:0] relu_out3;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out0;
   logic signed [DATA_W-1:0] out1;
   logic signed [DATA_W-1:0] out2;
   logic signed [DATA_W-1:0] out3;
   logic                     done;
   logic                     relu_err;

   modport master (
      output start, relu_out_ready, relu_out0, relu_out1, relu_out2, relu_out3, out_ready,
      input  busy, feat_idx, acc_clr, mac_en, relu_in_ready, out_valid,
      input  out0, out1, out2, out3, done, relu_err
   );

   modport slave (
      input  start, relu_out_ready, relu_out0, relu_out1, relu_out2, relu_out3, out_ready,
      output busy, feat_idx, acc_clr, mac_en, relu_in_ready, out_valid,
      output out0, out1, out2, out3, done, relu_err
   );

endinterface

// File: rtl/relu_layer_seq_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module seq_down_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/relu_layer_seq.sv
// Sequencer for one 4-neuron dense layer: clear, accumulate, drain the MAC
// pipeline, capture ReLU outputs and hand them downstream over valid/ready.
module relu_layer_seq
   import relu_seq_pkg::*;
#(
   parameter int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MAC_LAT    = DEF_MAC_LAT
) (
   input logic             clk,
   input logic             rst,
   relu_layer_seq_if.slave bus
);
   localparam int            IW         = idx_w(NUM_INPUTS);
   localparam int            CW         = idx_w(MAC_LAT + 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_INPUTS - 1);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

   seq_state_t                  state_q;
   logic [IW-1:0]               idx_q;
   logic                        busy_q;
   logic                        acc_clr_q;
   logic                        mac_en_q;
   logic                        rin_q;
   logic                        ov_q;
   logic                        done_q;
   logic                        err_q;
   logic [3:0][DATA_W-1:0]      out_q;

   logic                        cnt_load;
   logic                        cnt_dec;
   logic                        cnt_zero;
   logic                        any_neg;

   // Counter is armed on the last ACCUM cycle so DRAIN lasts exactly MAC_LAT cycles.
   assign cnt_load = (state_q == ACCUM) && (idx_q == LAST_IDX) && (MAC_LAT != 0);
   assign cnt_dec  = (state_q == DRAIN);

   seq_down_counter #(.W(CW)) u_drain_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (DRAIN_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   assign any_neg = bus.relu_out0[DATA_W-1] | bus.relu_out1[DATA_W-1] |
                    bus.relu_out2[DATA_W-1] | bus.relu_out3[DATA_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         acc_clr_q <= 1'b0;
         mac_en_q  <= 1'b0;
         rin_q     <= 1'b0;
         ov_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         out_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q   <= CLEAR;
                  busy_q    <= 1'b1;
                  acc_clr_q <= 1'b1;
                  idx_q     <= '0;
               end
            end
            CLEAR: begin
               state_q   <= ACCUM;
               acc_clr_q <= 1'b0;
               mac_en_q  <= 1'b1;
            end
            ACCUM: begin
               if (idx_q == LAST_IDX) begin
                  mac_en_q <= 1'b0;
                  idx_q    <= '0;
                  if (MAC_LAT == 0) begin
                     state_q <= ACTIVATE;
                     rin_q   <= 1'b1;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DRAIN: begin
               if (cnt_zero) begin
                  state_q <= ACTIVATE;
                  rin_q   <= 1'b1;
               end
            end
            ACTIVATE: begin
               if (bus.relu_out_ready) begin
                  out_q   <= {bus.relu_out3, bus.relu_out2, bus.relu_out1, bus.relu_out0};
                  err_q   <= err_q | any_neg;
                  rin_q   <= 1'b0;
                  ov_q    <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  ov_q   <= 1'b0;
                  done_q <= 1'b1;
                  // start on the transfer cycle chains straight into the next pass
                  if (bus.start) begin
                     state_q   <= CLEAR;
                     acc_clr_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.feat_idx      = idx_q;
   assign bus.acc_clr       = acc_clr_q;
   assign bus.mac_en        = mac_en_q;
   assign bus.relu_in_ready = rin_q;
   assign bus.out_valid     = ov_q;
   assign bus.done          = done_q;
   assign bus.relu_err      = err_q;
   assign bus.out0          = out_q[0];
   assign bus.out1          = out_q[1];
   assign bus.out2          = out_q[2];
   assign bus.out3          = out_q[3];

endmodule

// File: tb/tb_relu_layer_seq.sv
// Bench for relu_layer_seq: default-config DUT plus a NUM_INPUTS=2, MAC_LAT=0 DUT.
module tb_relu_layer_seq;
   import relu_seq_pkg::*;

   localparam int N  = DEF_NUM_INPUTS;
   localparam int DW = DEF_DATA_W;
   localparam int L  = DEF_MAC_LAT;

   logic clk = 1'b0;
   logic rst;
   logic hold_a;
   always #5 clk = ~clk;

   relu_layer_seq_if #(.NUM_INPUTS(N), .DATA_W(DW)) ia ();
   relu_layer_seq_if #(.NUM_INPUTS(2), .DATA_W(DW)) ib ();

   // Combinational ReLU stub: ready follows input_ready unless the bench stalls it.
   assign ia.relu_out_ready = ia.relu_in_ready & ~hold_a;
   assign ib.relu_out_ready = ib.relu_in_ready;

   relu_layer_seq #(.NUM_INPUTS(N), .DATA_W(DW), .MAC_LAT(L)) dut_a (
      .clk (clk), .rst (rst), .bus (ia.slave));
   relu_layer_seq #(.NUM_INPUTS(2), .DATA_W(DW), .MAC_LAT(0)) dut_b (
      .clk (clk), .rst (rst), .bus (ib.slave));

   int nchk = 0;
   int nerr = 0;
   logic signed [DW-1:0] exp_out [4];
   logic exp_err;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_relu(input logic signed [DW-1:0] v0, v1, v2, v3);
      ia.relu_out0 = v0; ia.relu_out1 = v1; ia.relu_out2 = v2; ia.relu_out3 = v3;
   endtask

   function automatic logic signed [DW-1:0] rnd_pos();
      return DW'($urandom_range(0, (1 << (DW - 1)) - 1));
   endfunction

   task automatic chk_outs_a(input string tag);
      chk({tag, "_out0"}, ia.out0, exp_out[0]);
      chk({tag, "_out1"}, ia.out1, exp_out[1]);
      chk({tag, "_out2"}, ia.out2, exp_out[2]);
      chk({tag, "_out3"}, ia.out3, exp_out[3]);
      chk({tag, "_err"},  ia.relu_err, exp_err);
   endtask

   // One pass on DUT A, checked cycle by cycle against the timing rules.
   // stall: cycles relu_out_ready is held low; bp: cycles out_ready is held low.
   task automatic pass_a(input bit pre_started, input int stall, input int bp, input bit b2b,
                         input logic signed [DW-1:0] v0, v1, v2, v3);
      if (!pre_started) begin
         ia.start = 1'b1;
         tick();
         ia.start = 1'b0;
      end
      chk("clear_acc_clr", ia.acc_clr, 1);
      chk("clear_mac_en", ia.mac_en, 0);
      chk("clear_idx", ia.feat_idx, 0);
      chk("clear_busy", ia.busy, 1);
      for (int k = 0; k < N; k++) begin
         tick();
         chk("accum_mac_en", ia.mac_en, 1);
         chk("accum_idx", ia.feat_idx, k);
         chk("accum_acc_clr", ia.acc_clr, 0);
      end
      for (int d = 0; d < L; d++) begin
         tick();
         chk("drain_enables", {ia.mac_en, ia.acc_clr, ia.relu_in_ready, ia.out_valid}, 0);
         chk("drain_idx", ia.feat_idx, 0);
         chk("drain_busy", ia.busy, 1);
      end
      hold_a = (stall > 0);
      if (stall > 0) set_relu(-1, -1, -1, -1);
      else           set_relu(v0, v1, v2, v3);
      tick();
      chk("act_rin", ia.relu_in_ready, 1);
      chk("act_ov", ia.out_valid, 0);
      chk("act_mac_en", ia.mac_en, 0);
      for (int s = 0; s < stall; s++) begin
         ia.start = 1'b1;
         tick();
         ia.start = 1'b0;
         chk("stall_rin", ia.relu_in_ready, 1);
         chk("stall_ov", ia.out_valid, 0);
      end
      hold_a = 1'b0;
      set_relu(v0, v1, v2, v3);
      tick();
      exp_out[0] = v0; exp_out[1] = v1; exp_out[2] = v2; exp_out[3] = v3;
      if (v0 < 0 || v1 < 0 || v2 < 0 || v3 < 0) exp_err = 1'b1;
      chk("hold_ov", ia.out_valid, 1);
      chk("hold_rin", ia.relu_in_ready, 0);
      chk("hold_busy", ia.busy, 1);
      chk_outs_a("hold");
      set_relu(rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());
      for (int b = 0; b < bp; b++) begin
         ia.out_ready = 1'b0;
         ia.start = 1'b1;
         tick();
         chk("bp_ov", ia.out_valid, 1);
         chk("bp_done", ia.done, 0);
         chk("bp_acc_clr", ia.acc_clr, 0);
         chk_outs_a("bp");
      end
      ia.out_ready = 1'b1;
      ia.start = b2b;
      tick();
      ia.out_ready = 1'b0;
      ia.start = 1'b0;
      chk("xfer_done", ia.done, 1);
      chk("xfer_ov", ia.out_valid, 0);
      chk("xfer_acc_clr", ia.acc_clr, b2b);
      chk("xfer_busy", ia.busy, b2b);
      if (!b2b) begin
         tick();
         chk("idle_done", ia.done, 0);
         chk("idle_busy", ia.busy, 0);
         chk("idle_acc_clr", ia.acc_clr, 0);
         chk_outs_a("idle");
      end
   endtask

   initial begin
      bit pre;
      bit b2b;
      rst = 1'b1;
      hold_a = 1'b0;
      ia.start = 1'b0; ia.out_ready = 1'b0;
      ib.start = 1'b0; ib.out_ready = 1'b0;
      set_relu(0, 0, 0, 0);
      ib.relu_out0 = 0; ib.relu_out1 = 0; ib.relu_out2 = 0; ib.relu_out3 = 0;
      for (int i = 0; i < 4; i++) exp_out[i] = '0;
      exp_err = 1'b0;
      tick();
      tick();
      chk("rst_busy", ia.busy, 0);
      chk("rst_ctl", {ia.feat_idx, ia.acc_clr, ia.mac_en, ia.relu_in_ready, ia.out_valid, ia.done}, 0);
      chk_outs_a("rst");
      chk("rst_b_ctl", {ib.busy, ib.feat_idx, ib.acc_clr, ib.mac_en, ib.out_valid, ib.done}, 0);
      rst = 1'b0;
      tick();
      chk("idle_no_start", ia.busy, 0);

      // Default pass with fixed stub values
      pass_a(0, 0, 1, 0, 5, 0, 7, 100);
      // Backpressure for 20 cycles with start pulses ignored
      pass_a(0, 0, 20, 0, rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());
      // Back-to-back passes
      pass_a(0, 0, 2, 1, rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());
      pass_a(1, 0, 0, 0, rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());
      // ReLU stall then negative value sets the sticky error
      pass_a(0, 5, 3, 0, rnd_pos(), -3, rnd_pos(), rnd_pos());
      pass_a(0, 0, 0, 0, rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());
      // Randomized passes
      pre = 1'b0;
      for (int r = 0; r < 6; r++) begin
         b2b = (r < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         pass_a(pre, $urandom_range(0, 3), $urandom_range(0, 4), b2b,
                rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());
         pre = b2b;
      end

      // Reset mid-ACCUM
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      repeat (5) tick();
      chk("mid_idx", ia.feat_idx, 4);
      chk("mid_mac_en", ia.mac_en, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) exp_out[i] = '0;
      exp_err = 1'b0;
      chk("abort_busy", ia.busy, 0);
      chk("abort_ctl", {ia.feat_idx, ia.acc_clr, ia.mac_en, ia.relu_in_ready, ia.out_valid, ia.done}, 0);
      chk_outs_a("abort");
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("abort_no_done", ia.done, 0);
         chk("abort_no_valid", ia.out_valid, 0);
      end
      pass_a(0, 0, 1, 0, rnd_pos(), rnd_pos(), rnd_pos(), rnd_pos());

      // NUM_INPUTS=2, MAC_LAT=0: valid four cycles after start, no drain cycle
      ib.relu_out0 = 11; ib.relu_out1 = 22; ib.relu_out2 = 0; ib.relu_out3 = 33;
      ib.start = 1'b1;
      tick();
      ib.start = 1'b0;
      chk("b_clear", ib.acc_clr, 1);
      tick();
      chk("b_mac0", {ib.mac_en, ib.feat_idx}, 2);
      tick();
      chk("b_mac1", {ib.mac_en, ib.feat_idx}, 3);
      tick();
      chk("b_act_no_drain", ib.relu_in_ready, 1);
      chk("b_act_ov", ib.out_valid, 0);
      tick();
      chk("b_ov_at_4", ib.out_valid, 1);
      chk("b_out", {ib.out3, ib.out2, ib.out1, ib.out0},
          {DW'(33), DW'(0), DW'(22), DW'(11)});
      chk("b_err", ib.relu_err, 0);
      ib.out_ready = 1'b1;
      tick();
      ib.out_ready = 1'b0;
      chk("b_done", ib.done, 1);
      tick();
      chk("b_idle", {ib.busy, ib.done}, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
